// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word and register-address types and
// architectural register constants used by the register file and the ALU.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam reg_addr_t RA_REG   = 5'd31;

endpackage

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file: two async read ports, one sync write port and a
// debug read port. Define REGFILE_WRITE_BYPASS_EN for write-through forwarding.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] DbgA,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] DbgRD
);
  import mips_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // $0 is hardwired, so storage starts at register 1
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  logic write_hit;
  assign write_hit = WE3 && (A3 != ZERO_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[A3] <= WD3;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = '0;
    if (addr != ZERO_ADDR) begin
      data = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward the pending write so a same-cycle read sees the new value
      if (!reset && write_hit && (addr == A3)) begin
        data = WD3;
      end
`endif
    end
    return data;
  endfunction

  always_comb begin
    RD1   = read_port(A1);
    RD2   = read_port(A2);
    DbgRD = read_port(DbgA);
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed cases from the test plan
// followed by randomized traffic compared against an array reference model.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, A3, DbgA;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2, DbgRD;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [32];

  mips_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .WE3(WE3), .DbgA(DbgA), .RD1(RD1), .RD2(RD2), .DbgRD(DbgRD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Expected combinational read value for the current input state
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!reset && WE3 && A3 == a) return WD3;
`endif
    return mdl[a];
  endfunction

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [31:0] wd, input logic we, input logic [4:0] dbg);
    A1 = a1; A2 = a2; A3 = a3; WD3 = wd; WE3 = we; DbgA = dbg;
  endtask

  // Advance from one negedge through a posedge to the next negedge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      foreach (mdl[i]) mdl[i] = 32'h0;
    end else if (WE3 && A3 != 5'd0) begin
      mdl[A3] = WD3;
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    drive(A1, A2, a, d, 1'b1, DbgA);
    tick();
    WE3 = 1'b0;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    reset = 1'b1;
    drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b1, 5'd0);
    repeat (3) begin
      @(negedge clk);
      drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b1, 5'd0);
    end
    WE3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      DbgA = 5'(i);
      #1 check($sformatf("reset_dbg%0d", i), DbgRD, 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read and write-enable gating
    wr(5'd5, 32'hDEADBEEF);
    drive(5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 5'd5);
    #1 check("wr_rd1", RD1, 32'hDEADBEEF);
    check("wr_rd2", RD2, 32'hDEADBEEF);
    drive(5'd5, 5'd5, 5'd5, 32'h1234, 1'b0, 5'd5);
    tick();
    check("we0_hold", RD1, 32'hDEADBEEF);

    // $0 protection
    wr(5'd1, 32'h0000_0777);
    wr(5'd0, 32'hFFFFFFFF);
    drive(5'd0, 5'd1, 5'd0, 32'h0, 1'b0, 5'd0);
    #1 check("zero_rd1", RD1, 32'h0);
    check("zero_dbg", DbgRD, 32'h0);
    check("zero_neighbour", RD2, 32'h0000_0777);

    // Same-cycle read/write hazard on reg 7
    wr(5'd7, 32'h11);
    drive(5'd7, 5'd7, 5'd7, 32'h22, 1'b1, 5'd7);
`ifdef REGFILE_WRITE_BYPASS_EN
    #1 check("hazard_pre", RD1, 32'h22);
`else
    #1 check("hazard_pre", RD1, 32'h11);
`endif
    tick();
    WE3 = 1'b0;
    #1 check("hazard_post", RD1, 32'h22);

    // Asynchronous reset between edges with a write pending
    wr(5'd31, 32'hA5A5A5A5);
    drive(5'd31, 5'd7, 5'd0, 32'h0, 1'b0, 5'd5);
    #1 check("ra_written", RD1, 32'hA5A5A5A5);
    drive(5'd31, 5'd7, 5'd31, 32'hCAFEF00D, 1'b1, 5'd5);
    #1 reset = 1'b1;
    #1 check("async_rst_rd1", RD1, 32'h0);
    check("async_rst_rd2", RD2, 32'h0);
    check("async_rst_dbg", DbgRD, 32'h0);
    tick();
    #1 check("rst_blocks_write", RD1, 32'h0);
    reset = 1'b0;
    WE3 = 1'b0;
    @(negedge clk);

    // Full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 5'(i));
      #1 check($sformatf("sweep_rd1_%0d", i), RD1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_%0d", i), RD2, 32'(31 - i) * 32'h01010101);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom));
      if ($urandom_range(0, 3) == 0) A2 = A1;
      #1;
      check("rnd_rd1", RD1, expect_rd(A1));
      check("rnd_rd2", RD2, expect_rd(A2));
      check("rnd_dbg", DbgRD, expect_rd(DbgA));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
